// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared 1-bit full adder, LSB first, one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.

module fa (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(WIDTH - 2);

  state_t           r_state;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic             r_cy;
  logic             r_cmsb;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_b_cap;
  logic             w_ci_cap;

  fa u_fa (
    .s  (w_sum),
    .co (w_co),
    .a  (r_sha[0]),
    .b  (r_shb[0]),
    .ci (r_cy)
  );

  // Subtraction is a + ~b + 1, so only the captured operand and carry change.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    w_b_cap  = sub ? ~b : b;
    w_ci_cap = sub ? 1'b1 : ci;
`else
    w_b_cap  = b;
    w_ci_cap = ci;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sha   <= '0;
      r_shb   <= '0;
      r_cy    <= 1'b0;
      r_cmsb  <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_sha   <= a;
            r_shb   <= w_b_cap;
            r_cy    <= w_ci_cap;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sha <= {1'b0, r_sha[WIDTH-1:1]};
          r_shb <= {1'b0, r_shb[WIDTH-1:1]};
          s     <= {w_sum, s[WIDTH-1:1]};
          r_cy  <= w_co;
          r_cnt <= r_cnt + CNT_W'(1);
          // Carry out of bit WIDTH-2 is the carry into the MSB.
          if (r_cnt == PENULT) r_cmsb <= w_co;
          if (r_cnt == LAST) begin
            co      <= w_co;
            ovf     <= r_cmsb ^ w_co;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes expected results, a negedge monitor checks them.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         ci;
  logic         sub;
  logic         busy, done, co, ovf;
  logic [W-1:0] s;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   done_seen = 0;
  int   pushed = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse and checks latency and busy width.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        exp_t e;
        done_seen++;
        if (q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("sum", 32'(s), 32'(e.s));
          check("co", 32'(co), 32'(e.co));
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("latency", 32'(cyc - t_start), 32'(W));
          check("busy_cycles", 32'(busy_cnt), 32'(W));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                       input logic tsub, input bit expect_res,
                       input logic [W-1:0] es, input logic eco, input logic eovf);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_; ci = tci; sub = tsub; start = 1'b1;
    if (expect_res) begin
      e.s = es; e.co = eco; e.ovf = eovf;
      q.push_back(e);
      pushed++;
    end
    @(posedge clk);
    #1;
    t_start = cyc;
    start = 1'b0;
    a = ~ta; b = ~tb_; ci = ~tci;
  endtask

  task automatic wait_done();
    int n0 = done_seen;
    for (int k = 0; k < 4 * W && done_seen == n0; k++) begin
      @(negedge clk);
      #1;
    end
    check("done_timeout", 32'(done_seen != n0), 32'd1);
  endtask

  task automatic check_outputs(input string nm, input logic [W-1:0] es, input logic eco,
                               input logic eovf);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_done"}, 32'(done), 32'd0);
    check({nm, "_s"}, 32'(s), 32'(es));
    check({nm, "_co"}, 32'(co), 32'(eco));
    check({nm, "_ovf"}, 32'(ovf), 32'(eovf));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_outputs("idle", 8'h00, 1'b0, 1'b0);
    end

    issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_outputs("hold", 8'h10, 1'b0, 1'b0);
    end

    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0); wait_done();
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0); wait_done();
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1); wait_done();
    issue(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1); wait_done();
    issue(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1); wait_done();
    issue(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0); wait_done();

    // Start re-pulsed mid-RUN must be ignored.
    issue(8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'h55; b = 8'h55; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);

    // Reset during RUN aborts with no done pulse.
    issue(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("abort", 8'h00, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    check_outputs("after_abort", 8'h00, 1'b0, 1'b0);
    issue(8'h40, 8'h23, 1'b0, 1'b0, 1'b1, 8'h63, 1'b0, 1'b0); wait_done();

`ifdef SERIAL_ADD_SUB_EN
    issue(8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0); wait_done();
    issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1); wait_done();
    issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0); wait_done();
`endif

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 32'(q.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
